// File: rtl/reorder_request_tagger.sv
// rtl/reorder_request_tagger.sv - reorder-tag allocator with 2-entry tagged output buffer
// Optional tag-sequence checker: define REORDER_TAGGER_TAG_CHECK_EN.
module reorder_request_tagger #(
   parameter int ADDR_WIDTH      = 48,
   parameter int TAG_WIDTH       = 6,
   parameter int MAX_OUTSTANDING = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  rq_increment,
   input  logic [TAG_WIDTH-1:0]  rq_index_tag,
   input  logic                  rq_full,
   input  logic                  rq_valid,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic [TAG_WIDTH-1:0]  mem_req_tag,
   input  logic                  mem_req_stall,
   output logic [TAG_WIDTH:0]    outstanding,
   output logic                  tag_error
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   localparam logic [TAG_WIDTH:0] MAX_OUT = (TAG_WIDTH+1)'(MAX_OUTSTANDING);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_head_addr;
   logic [ADDR_WIDTH-1:0] r_tail_addr;
   logic [TAG_WIDTH-1:0]  r_head_tag;
   logic [TAG_WIDTH-1:0]  r_tail_tag;
   logic [TAG_WIDTH:0]    r_outstanding;

   logic w_ready;
   logic w_accept;
   logic w_pop;
   logic w_retire;

   assign w_ready  = !rst && !rq_full && (r_state != FULL) && (r_outstanding < MAX_OUT);
   assign w_accept = req_valid && w_ready;
   assign w_pop    = (r_state != EMPTY) && !mem_req_stall;
   // A retire with nothing in flight is dropped so the counter cannot wrap.
   assign w_retire = rq_valid && (r_outstanding != '0);

   assign req_ready     = w_ready;
   assign rq_increment  = w_accept;
   assign mem_req_valid = !rst && (r_state != EMPTY);
   assign mem_req_addr  = rst ? '0 : r_head_addr;
   assign mem_req_tag   = rst ? '0 : r_head_tag;
   assign outstanding   = rst ? '0 : r_outstanding;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= EMPTY;
         r_head_addr   <= '0;
         r_head_tag    <= '0;
         r_tail_addr   <= '0;
         r_tail_tag    <= '0;
         r_outstanding <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_head_addr <= req_addr;
                  r_head_tag  <= rq_index_tag;
                  r_state     <= ONE;
               end
            end
            ONE: begin
               if (w_accept && !w_pop) begin
                  r_tail_addr <= req_addr;
                  r_tail_tag  <= rq_index_tag;
                  r_state     <= FULL;
               end else if (w_accept && w_pop) begin
                  r_head_addr <= req_addr;
                  r_head_tag  <= rq_index_tag;
               end else if (w_pop) begin
                  r_state <= EMPTY;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_head_addr <= r_tail_addr;
                  r_head_tag  <= r_tail_tag;
                  r_state     <= ONE;
               end
            end
            default: r_state <= EMPTY;
         endcase

         if (w_accept && !w_retire) begin
            r_outstanding <= r_outstanding + 1'b1;
         end else if (!w_accept && w_retire) begin
            r_outstanding <= r_outstanding - 1'b1;
         end
      end
   end

`ifdef REORDER_TAGGER_TAG_CHECK_EN
   logic [TAG_WIDTH-1:0] r_expected_tag;
   logic                 r_tag_error;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_expected_tag <= '0;
         r_tag_error    <= 1'b0;
      end else if (w_accept) begin
         r_expected_tag <= r_expected_tag + 1'b1;
         if (rq_index_tag != r_expected_tag) begin
            r_tag_error <= 1'b1;
         end
      end
   end

   assign tag_error = !rst && r_tag_error;
`else
   assign tag_error = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_request_tagger.sv
// tb/tb_reorder_request_tagger.sv - randomized bench against a queue-based reference model
module tb_reorder_request_tagger;

   localparam int AW   = 48;
   localparam int TW   = 6;
   localparam int MAXO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          req_ready;
   logic          rq_increment;
   logic [TW-1:0] rq_index_tag = '0;
   logic          rq_full = 1'b0;
   logic          rq_valid = 1'b0;
   logic          mem_req_valid;
   logic [AW-1:0] mem_req_addr;
   logic [TW-1:0] mem_req_tag;
   logic          mem_req_stall = 1'b0;
   logic [TW:0]   outstanding;
   logic          tag_error;

   always #5 clk = ~clk;

   reorder_request_tagger #(
      .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .rq_increment(rq_increment), .rq_index_tag(rq_index_tag),
      .rq_full(rq_full), .rq_valid(rq_valid),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_tag(mem_req_tag), .mem_req_stall(mem_req_stall),
      .outstanding(outstanding), .tag_error(tag_error)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [TW-1:0] tag;
   } entry_t;

   // Reference model: in-order FIFO of forwarded requests, in-flight count, tag sequence.
   entry_t m_q[$];
   int     m_cnt      = 0;
   int     m_exp_tag  = 0;
   bit     m_err      = 1'b0;
   int     queue_tag  = 0;
   int     seen_incr  = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input logic v, input logic [AW-1:0] a, input logic full,
                       input logic rqv, input logic stall, input logic bad_tag,
                       input logic do_rst);
      bit exp_ready;
      bit exp_acc;
      bit exp_tag_err;
      @(negedge clk);
      rst           = do_rst;
      req_valid     = v;
      req_addr      = a;
      rq_full       = full;
      rq_valid      = rqv;
      mem_req_stall = stall;
      rq_index_tag  = TW'(bad_tag ? queue_tag + 1 : queue_tag);
      #1;
      exp_ready = !do_rst && !full && (m_q.size() < 2) && (m_cnt < MAXO);
      exp_acc   = v && exp_ready;
`ifdef REORDER_TAGGER_TAG_CHECK_EN
      exp_tag_err = !do_rst && m_err;
`else
      exp_tag_err = 1'b0;
`endif
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("rq_increment", 64'(rq_increment), 64'(exp_acc));
      check("mem_req_valid", 64'(mem_req_valid), 64'(!do_rst && m_q.size() > 0));
      check("outstanding", 64'(outstanding), do_rst ? 64'd0 : 64'(m_cnt));
      check("tag_error", 64'(tag_error), 64'(exp_tag_err));
      if (do_rst) begin
         check("rst_addr", 64'(mem_req_addr), 64'd0);
         check("rst_tag", 64'(mem_req_tag), 64'd0);
      end else if (m_q.size() > 0) begin
         check("mem_req_addr", 64'(mem_req_addr), 64'(m_q[0].addr));
         check("mem_req_tag", 64'(mem_req_tag), 64'(m_q[0].tag));
      end
      if (rq_increment) seen_incr++;
      @(posedge clk);
      if (do_rst) begin
         m_q.delete();
         m_cnt     = 0;
         m_exp_tag = 0;
         m_err     = 1'b0;
         queue_tag = 0;
      end else begin
         if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
         if (rqv && m_cnt > 0) m_cnt--;
         if (exp_acc) begin
            m_cnt++;
            if (int'(rq_index_tag) != m_exp_tag) m_err = 1'b1;
            m_exp_tag = (m_exp_tag + 1) % (1 << TW);
            m_q.push_back('{addr: a, tag: rq_index_tag});
            queue_tag = (queue_tag + 1) % (1 << TW);
         end
      end
   endtask

   initial begin
      // Reset held for several cycles, then idle.
      for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 0, 0, 1);
      step(0, '0, 0, 0, 0, 0, 0);

      // Back-to-back requests, no stall.
      for (int i = 0; i < 4; i++) step(1, AW'(48'h10 + i), 0, 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0, 0);
      check("tp2_outstanding", 64'(outstanding), 64'd4);

      // Memory stall with continuous requests: buffer fills at two.
      step(0, '0, 0, 0, 0, 0, 1);
      seen_incr = 0;
      for (int i = 0; i < 6; i++) step(1, AW'(48'h100 + i), 0, 0, 1, 0, 0);
      check("stall_accepts", 64'(seen_incr), 64'd2);
      for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 0, 0, 0);

      // Reorder queue full blocks issue.
      step(0, '0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, AW'(48'h200 + i), 1, 0, 0, 0, 0);
      step(1, 48'h203, 0, 0, 0, 0, 0);

      // Outstanding cap, single retire, simultaneous accept and retire.
      step(0, '0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, AW'(48'h300 + i), 0, 0, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0, 0);
      step(1, 48'h310, 0, 0, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0, 0);
      step(1, 48'h311, 0, 1, 0, 0, 0);
      check("cap_outstanding", 64'(outstanding), 64'd3);
      // Retire with nothing in flight must not underflow.
      step(0, '0, 0, 0, 0, 0, 1);
      step(0, '0, 0, 1, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0, 0);

      // Tag sequence 0,1,3 then hold.
      step(0, '0, 0, 0, 0, 0, 1);
      step(1, 48'h400, 0, 0, 0, 0, 0);
      step(1, 48'h401, 0, 0, 0, 0, 0);
      step(1, 48'h402, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0, 1);
      step(0, '0, 0, 0, 0, 0, 0);

      // Randomized traffic, including tag wrap and occasional mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 7, {$urandom, $urandom},
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 3, $urandom_range(0, 499) == 0,
              $urandom_range(0, 399) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
